// File: rtl/nibble_accumulator.sv
// rtl/nibble_accumulator.sv - accumulates N_OPS nibbles through an external 4-bit adder
// Result is held on a valid/ready port until downstream takes it.
module nibble_accumulator #(
  parameter int N_OPS    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic [3:0] adder_a,
  output logic [3:0] adder_b,
  input  logic [3:0] adder_s,
  input  logic       adder_c,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic       out_ovf
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [3:0] CNT_LAST = 4'(N_OPS - 1);

  state_t     state, state_nxt;
  logic [3:0] acc, acc_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       ovf, ovf_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
      acc   <= 4'h0;
      cnt   <= 4'h0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    if (clr) begin
      state_nxt = ACC;
      acc_nxt   = 4'h0;
      cnt_nxt   = 4'h0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            // Saturating mode pins the total at F once any add carries out.
            acc_nxt = (SATURATE && adder_c) ? 4'hF : adder_s;
            ovf_nxt = ovf | adder_c;
            if (cnt == CNT_LAST) begin
              cnt_nxt   = 4'h0;
              state_nxt = HOLD;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc_nxt   = 4'h0;
            ovf_nxt   = 1'b0;
            state_nxt = ACC;
          end
        end
        default: state_nxt = ACC;
      endcase
    end
  end

  assign adder_a   = in_data;
  assign adder_b   = acc;
  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_nibble_accumulator.sv
// tb/tb_nibble_accumulator.sv - four accumulator variants against a list-of-operands model
// Shared stimulus; per-variant expectations are folded from the accepted operand list.
module tb_nibble_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  logic [3:0] in_ready_v;
  logic [3:0] out_valid_v;
  logic [3:0] out_ovf_v;
  logic [3:0] adder_c_v;
  logic [3:0] out_sum_v [4];
  logic [3:0] adder_a_v [4];
  logic [3:0] adder_b_v [4];
  logic [3:0] adder_s_v [4];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Variants: 0 = (4,wrap) 1 = (4,sat) 2 = (3,wrap) 3 = (1,wrap)
  function automatic int nops(input int i);
    return (i == 3) ? 1 : (i == 2) ? 3 : 4;
  endfunction

  function automatic bit sat(input int i);
    return (i == 1);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NOPS = (g == 3) ? 1 : (g == 2) ? 3 : 4;
    assign {adder_c_v[g], adder_s_v[g]} = {1'b0, adder_a_v[g]} + {1'b0, adder_b_v[g]};
    nibble_accumulator #(.N_OPS(NOPS), .SATURATE(g == 1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .in_data   (in_data),
      .adder_a   (adder_a_v[g]),
      .adder_b   (adder_b_v[g]),
      .adder_s   (adder_s_v[g]),
      .adder_c   (adder_c_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .out_sum   (out_sum_v[g]),
      .out_ovf   (out_ovf_v[g])
    );
  end

  // Model: the operands accepted so far in the current group.
  logic [3:0] ops [4][16];
  int         nacc [4];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n || clr) nacc[i] = 0;
      else if (nacc[i] < nops(i)) begin
        if (in_valid) begin
          ops[i][nacc[i]] = in_data;
          nacc[i] = nacc[i] + 1;
        end
      end else if (out_ready) nacc[i] = 0;
    end
  end

  task automatic fold(input int i, output int total, output bit carry);
    total = 0;
    carry = 1'b0;
    for (int k = 0; k < nacc[i]; k++) begin
      total = total + int'(ops[i][k]);
      if (total > 15) begin
        carry = 1'b1;
        total = sat(i) ? 15 : total - 16;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int  t;
    bit  c;
    bit  full;
    for (int i = 0; i < 4; i++) begin
      fold(i, t, c);
      full = (nacc[i] == nops(i));
      chk($sformatf("in_ready[%0d]", i), int'(in_ready_v[i]), int'(!full));
      chk($sformatf("out_valid[%0d]", i), int'(out_valid_v[i]), int'(full));
      chk($sformatf("adder_a[%0d]", i), int'(adder_a_v[i]), int'(in_data));
      chk($sformatf("adder_b[%0d]", i), int'(adder_b_v[i]), t);
      if (full) begin
        chk($sformatf("out_sum[%0d]", i), int'(out_sum_v[i]), t);
        chk($sformatf("out_ovf[%0d]", i), int'(out_ovf_v[i]), int'(c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    tick(); tick();
    chk("reset in_ready", int'(in_ready_v[0]), 1);
    chk("reset out_valid", int'(out_valid_v[0]), 0);
    chk("reset out_sum", int'(out_sum_v[0]), 0);
    rst_n = 1'b1;
    tick();

    // 1,2,3,4 -> A, then immediate release
    out_ready = 1'b1;
    send(4'd1); send(4'd2); send(4'd3); send(4'd4);
    in_valid = 1'b0;
    chk("t1 out_valid", int'(out_valid_v[0]), 1);
    chk("t1 out_sum", int'(out_sum_v[0]), 10);
    chk("t1 out_ovf", int'(out_ovf_v[0]), 0);
    tick();
    chk("t1 in_ready after release", int'(in_ready_v[0]), 1);
    chk("t1 acc cleared", int'(adder_b_v[0]), 0);

    // 8,8,1,0 wrap vs saturate
    do_clr();
    out_ready = 1'b0;
    send(4'd8); send(4'd8); send(4'd1); send(4'd0);
    in_valid = 1'b0;
    chk("t2 wrap sum", int'(out_sum_v[0]), 1);
    chk("t2 wrap ovf", int'(out_ovf_v[0]), 1);
    chk("t2 sat sum", int'(out_sum_v[1]), 15);
    chk("t2 sat ovf", int'(out_ovf_v[1]), 1);

    // backpressure: 3+4+5+6 = 18 -> 2 with carry, offered 7 is refused
    do_clr();
    send(4'd3); send(4'd4); send(4'd5); send(4'd6);
    in_data = 4'd7;
    for (int k = 0; k < 5; k++) begin
      chk("t3 in_ready held", int'(in_ready_v[0]), 0);
      chk("t3 out_sum held", int'(out_sum_v[0]), 2);
      chk("t3 out_ovf held", int'(out_ovf_v[0]), 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t3 released valid", int'(out_valid_v[0]), 0);
    chk("t3 released ready", int'(in_ready_v[0]), 1);
    tick();
    chk("t3 seven accepted", int'(adder_b_v[0]), 7);
    in_valid = 1'b0;

    // clr mid-accumulation and during HOLD
    do_clr();
    send(4'd5); send(4'd6);
    in_data = 4'd9;
    do_clr();
    in_valid = 1'b0;
    chk("t4 clr acc", int'(adder_b_v[0]), 0);
    out_ready = 1'b0;
    send(4'd1); send(4'd1); send(4'd1); send(4'd1);
    in_valid = 1'b0;
    chk("t4 sum", int'(out_sum_v[0]), 4);
    chk("t4 ovf", int'(out_ovf_v[0]), 0);
    do_clr();
    chk("t4 clr drops hold", int'(out_valid_v[0]), 0);

    // asynchronous reset mid-ACC and mid-HOLD
    out_ready = 1'b1;
    send(4'd3); send(4'd3); send(4'd3);
    in_valid = 1'b0;
    rst_n = 1'b0; #1;
    chk("t5 rst acc in_ready", int'(in_ready_v[0]), 1);
    chk("t5 rst acc value", int'(adder_b_v[0]), 0);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b0;
    send(4'd2); send(4'd2); send(4'd2); send(4'd2);
    in_valid = 1'b0;
    chk("t5 sum", int'(out_sum_v[0]), 8);
    rst_n = 1'b0; #1;
    chk("t5 rst hold valid", int'(out_valid_v[0]), 0);
    chk("t5 rst hold in_ready", int'(in_ready_v[0]), 1);
    chk("t5 rst hold sum", int'(out_sum_v[0]), 0);
    rst_n = 1'b1;
    tick();

    // N_OPS=3 with gaps: 15,1,0 -> 0 with carry; N_OPS=1 passes operand through
    do_clr();
    begin
      logic [3:0] seq [3];
      seq[0] = 4'd15; seq[1] = 4'd1; seq[2] = 4'd0;
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 4)) tick();
        send(seq[k]);
      end
    end
    in_valid = 1'b0;
    chk("t6 n3 valid", int'(out_valid_v[2]), 1);
    chk("t6 n3 sum", int'(out_sum_v[2]), 0);
    chk("t6 n3 ovf", int'(out_ovf_v[2]), 1);
    do_clr();
    send(4'd9);
    in_valid = 1'b0;
    chk("t6 n1 sum", int'(out_sum_v[3]), 9);
    chk("t6 n1 ovf", int'(out_ovf_v[3]), 0);

    // random traffic, checked every cycle by the monitor
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 31) == 0);
      tick();
      if ($urandom_range(0, 127) == 0) begin
        rst_n = 1'b0; #1;
        rst_n = 1'b1;
      end
    end
    clr = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
